mdu_iterative: RTL and testbench
================================

# mdu_iterative

Parametrised iterative multiply/divide unit, the next generation of the processor's MDU. It replaces the fixed 32-bit single-cycle multiplier/IP-core divider pair with one radix-2 shift/add/subtract datapath of configurable width. It supports signed and unsigned multiply and divide, returns both result halves (product high/low, remainder/quotient) and uses an explicit start/busy/valid handshake. It sits in the execute stage; the pipeline stalls on `oBusy`.

## Interface
- `WIDTH`, 32: operand width in bits, ≥ 4.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width.

Ports:
- `iClk`  in  1  clock; all logic on rising edge.
- `iRst_n`  in  1  synchronous, active-low reset.
- `iStart`  in  1  request; accepted on an edge where `iStart=1` and `oBusy=0`.
- `iOp`  in  2  operation: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- `iSrc0`  in  WIDTH  multiplicand / dividend.
- `iSrc1`  in  WIDTH  multiplier / divisor.
- `oBusy`  out  1  operation in progress; new requests are ignored.
- `oValid`  out  1  one-cycle pulse: `oHi`/`oLo` are valid.
- `oHi`  out  WIDTH  MUL: product[2W-1:W]; DIV: remainder.
- `oLo`  out  WIDTH  MUL: product[W-1:0]; DIV: quotient.
- `oDivByZero`  out  1  set with `oValid` when a DIV had divisor 0.

## Operation
- FSM: IDLE → CALC → FIX → DONE → IDLE.
  - On accept: `iOp` and the operand magnitudes are latched. Signed ops take the absolute value; result signs are recorded. Counter is loaded with WIDTH.
- CALC, WIDTH cycles, one bit per cycle:
  - MUL: conditional add of the multiplicand into a 2W accumulator, then shift right.
  - DIV: restoring shift/subtract, producing one quotient bit per cycle.
- FIX, 1 cycle: sign correction.
  - MULS: negate the 2W product if the operand signs differ.
  - DIVS: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncation toward zero).
- DONE, 1 cycle: `oValid=1`, `oBusy=0`. `iStart` in DONE is accepted, allowing back-to-back operations.
- `oHi`, `oLo` and `oDivByZero` hold their values until the next FIX completes. They never change while in IDLE.
- Divide by zero: quotient = all ones, remainder = dividend (unsigned and signed), `oDivByZero=1`, full latency.
- Signed overflow: DIVS of MIN by −1 gives quotient = MIN and remainder = 0, with no flag.
- `iStart` while `oBusy=1` is ignored, with no side effects. `iOp`/`iSrc*` are don't-care except on the accept edge.

## Timing
- Reset (`iRst_n=0` at an edge): FSM → IDLE; `oBusy`, `oValid`, `oDivByZero` = 0; `oHi`, `oLo` = 0.
  - Reset mid-operation aborts the operation; no `oValid` follows.
- Accept at edge E0: `oBusy=1` from E0 through E0+WIDTH+1.
- `oValid=1` in the cycle after edge E0+WIDTH+1, i.e. visible at E0+WIDTH+2. Latency is WIDTH+2 cycles; with WIDTH=32, `oValid` is seen 34 edges after accept.
- Throughput: one operation per WIDTH+2 cycles when back-to-back.
- Reset takes priority over `iStart` on the same edge.

## Configuration
- `MDU_SIGNED_EN` defined: MULS/DIVS supported as above. This costs the abs/negate logic and the sign registers.
- Not defined: `iOp[0]` is ignored and all operations are unsigned. MULS behaves as MULU, DIVS as DIVU. Latency is unchanged, and FIX passes results through.

## Test plan
- MULU (WIDTH=32): FFFFFFFF × FFFFFFFF → `oHi`=FFFFFFFE, `oLo`=00000001, `oValid` exactly 34 edges after accept.
- MULS: FFFFFFFD × 00000005 → `oHi`=FFFFFFFF, `oLo`=FFFFFFF1. Without `MDU_SIGNED_EN`: `oHi`=00000004, `oLo`=FFFFFFF1.
- DIVS: FFFFFFF9 ÷ 00000002 → `oLo`=FFFFFFFD, `oHi`=FFFFFFFF. DIVS 80000000 ÷ FFFFFFFF → `oLo`=80000000, `oHi`=00000000.
- DIVU: 00000064 ÷ 0 → `oLo`=FFFFFFFF, `oHi`=00000064, `oDivByZero`=1. The next valid operation clears `oDivByZero`.
- Handshake: `iStart` held high continuously.
  - Second accept occurs in the DONE cycle; pulses spaced 34 cycles apart.
  - `iStart` pulses during `oBusy` are ignored.
- Reset: assert `iRst_n=0` at CALC cycle 10 → next cycle all outputs 0, state IDLE, no `oValid`. The next request completes normally.

Source files
------------

// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and mdu_iterative.
// The master drives requests and the slave (the MDU) returns results.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             iStart;
    logic [1:0]       iOp;
    logic [WIDTH-1:0] iSrc0;
    logic [WIDTH-1:0] iSrc1;
    logic             oBusy;
    logic             oValid;
    logic [WIDTH-1:0] oHi;
    logic [WIDTH-1:0] oLo;
    logic             oDivByZero;

    modport master (
        output iStart, iOp, iSrc0, iSrc1,
        input  oBusy, oValid, oHi, oLo, oDivByZero
    );

    modport slave (
        input  iStart, iOp, iSrc0, iSrc1,
        output oBusy, oValid, oHi, oLo, oDivByZero
    );
endinterface

// File: rtl/mdu_iterative.sv
// Radix-2 iterative multiply/divide unit (shift/add multiply, restoring divide).
// Define MDU_SIGNED_EN for MULS/DIVS; otherwise iOp[0] is ignored and all ops are unsigned.
module mdu_iterative #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic iClk,
    input  logic iRst_n,
    mdu_if.slave bus
);
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             accept_c;
    logic [WIDTH-1:0] mag0_c, mag1_c;
    logic             neg_prod_c, neg_quo_c, neg_rem_c;
    logic [WIDTH:0]   sum_c, rem_sh_c, diff_c;
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] quo_c, rem_c;

    assign accept_c = bus.iStart && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef MDU_SIGNED_EN
    logic src0_neg_c, src1_neg_c;
    logic sgn_res_q, sgn_res_d, sgn_rem_q, sgn_rem_d;

    assign src0_neg_c = bus.iOp[0] & bus.iSrc0[WIDTH-1];
    assign src1_neg_c = bus.iOp[0] & bus.iSrc1[WIDTH-1];
    assign mag0_c     = src0_neg_c ? WIDTH'(-bus.iSrc0) : bus.iSrc0;
    assign mag1_c     = src1_neg_c ? WIDTH'(-bus.iSrc1) : bus.iSrc1;
    assign sgn_res_d  = accept_c ? (src0_neg_c ^ src1_neg_c) : sgn_res_q;
    assign sgn_rem_d  = accept_c ? src0_neg_c : sgn_rem_q;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sgn_res_q <= 1'b0;
            sgn_rem_q <= 1'b0;
        end else begin
            sgn_res_q <= sgn_res_d;
            sgn_rem_q <= sgn_rem_d;
        end
    end

    // A zero divisor keeps the all-ones quotient regardless of operand signs
    assign neg_prod_c = sgn_res_q;
    assign neg_quo_c  = sgn_res_q & (opnd_q != '0);
    assign neg_rem_c  = sgn_rem_q;
`else
    logic unused_op0;
    assign unused_op0 = bus.iOp[0];
    assign mag0_c     = bus.iSrc0;
    assign mag1_c     = bus.iSrc1;
    assign neg_prod_c = 1'b0;
    assign neg_quo_c  = 1'b0;
    assign neg_rem_c  = 1'b0;
`endif

    assign prod_c = neg_prod_c ? AW'(-acc_q) : acc_q;
    assign quo_c  = neg_quo_c ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_c  = neg_rem_c ? WIDTH'(-acc_q[AW-1:WIDTH]) : acc_q[AW-1:WIDTH];

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    // acc holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        sum_c    = '0;
        rem_sh_c = '0;
        diff_c   = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) state_d = S_IDLE;
                if (accept_c) begin
                    state_d  = S_CALC;
                    cnt_d    = CNT_W'(WIDTH);
                    is_div_d = bus.iOp[1];
                    opnd_d   = bus.iOp[1] ? mag1_c : mag0_c;
                    acc_d    = {{WIDTH{1'b0}}, (bus.iOp[1] ? mag0_c : mag1_c)};
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                if (is_div_q) begin
                    rem_sh_c = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
                    diff_c   = rem_sh_c - {1'b0, opnd_q};
                    if (diff_c[WIDTH]) acc_d = {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    else               acc_d = {diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    sum_c = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
                    acc_d = {sum_c, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                dbz_d   = is_div_q && (opnd_q == '0);
                if (is_div_q) begin
                    hi_d = rem_c;
                    lo_d = quo_c;
                end else begin
                    hi_d = prod_c[AW-1:WIDTH];
                    lo_d = prod_c[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d == S_CALC) || (state_d == S_FIX);
        valid_d = (state_d == S_DONE);
    end

    assign bus.oBusy      = busy_q;
    assign bus.oValid     = valid_q;
    assign bus.oHi        = hi_q;
    assign bus.oLo        = lo_q;
    assign bus.oDivByZero = dbz_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed corner cases, handshake, reset and random ops
// against an arithmetic reference model (follows MDU_SIGNED_EN like the design).
module tb_mdu_iterative;
    localparam int unsigned W   = 32;
    localparam int          LAT = W + 2;
`ifdef MDU_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mdu_if #(.WIDTH(W)) bus ();

    mdu_iterative #(.WIDTH(W)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from plain integer arithmetic
    function automatic logic [2*W:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        bit             sgn;
        longint         sa, sb;
        logic [2*W-1:0] p;
        logic [W-1:0]   q, r;
        sgn = SIGNED_EN && op[0];
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (!op[1]) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        q = W'(sa / sb);
        r = W'(sa % sb);
        return {1'b0, r, q};
    endfunction

    // Enters and leaves on a falling edge; lat counts edges from accept to the edge sampling oValid
    task automatic wait_valid(output int lat, input bit inject);
        lat = 0;
        @(negedge clk);
        while (!bus.oValid && lat < 100) begin
            if (inject) begin
                if (lat == 5 || lat == 12 || lat == 20) begin
                    bus.iStart = 1'b1;
                    bus.iOp    = 2'($urandom);
                    bus.iSrc0  = $urandom;
                    bus.iSrc1  = $urandom;
                end else begin
                    bus.iStart = 1'b0;
                end
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        lat++;
        check_eq("valid_seen", 64'(bus.oValid), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [2*W:0] exp, input int lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
        check_eq({tag, "_hi"}, 64'(bus.oHi), 64'(exp[2*W-1:W]));
        check_eq({tag, "_lo"}, 64'(bus.oLo), 64'(exp[W-1:0]));
        check_eq({tag, "_dbz"}, 64'(bus.oDivByZero), 64'(exp[2*W]));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit inject);
        logic [2*W:0] exp;
        int           lat;
        exp = ref_model(op, a, b);
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iOp    = op;
        bus.iSrc0  = a;
        bus.iSrc1  = b;
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        check_eq({tag, "_busy"}, 64'(bus.oBusy), 64'd1);
        wait_valid(lat, inject);
        check_result(tag, exp, lat);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, 64'(bus.oValid), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_hold"}, {bus.oHi, bus.oLo}, exp[2*W-1:0]);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2*W:0] exp1, exp2;
        int           lat, n_valid;

        bus.iStart = 1'b0;
        bus.iOp    = '0;
        bus.iSrc0  = '0;
        bus.iSrc1  = '0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {bus.oBusy, bus.oValid, bus.oDivByZero, bus.oHi, bus.oLo},
                 {3'b000, 64'd0});
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("mulu_max_const", {bus.oHi, bus.oLo}, 64'hFFFF_FFFE_0000_0001);
        run_op("muls_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
        run_op("divs_trunc", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op("divs_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_zero", 2'b10, 32'h0000_0064, 32'h0000_0000, 1'b0);
        run_op("dbz_clear", 2'b00, 32'h0000_1234, 32'h0000_5678, 1'b0);
        run_op("divs_zero", 2'b11, 32'hFFFF_FF00, 32'h0000_0000, 1'b0);

        // Reset in the middle of CALC aborts the op and clears every output
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iOp    = 2'b00;
        bus.iSrc0  = 32'hDEAD_BEEF;
        bus.iSrc1  = 32'h0000_1234;
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midop_reset", {bus.oBusy, bus.oValid, bus.oDivByZero, bus.oHi, bus.oLo},
                 {3'b000, 64'd0});
        @(negedge clk);
        rst_n   = 1'b1;
        n_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.oValid) n_valid++;
        end
        check_eq("no_valid_after_reset", 64'(n_valid), 64'd0);
        run_op("after_reset", 2'b10, 32'h0000_03E8, 32'h0000_0007, 1'b0);

        run_op("busy_ignore", 2'b10, 32'h1234_5678, 32'h0000_0101, 1'b1);

        // iStart held high: second accept lands on the DONE cycle
        exp1 = ref_model(2'b00, 32'h0001_0003, 32'h0002_0005);
        exp2 = ref_model(2'b11, 32'h8000_0001, 32'h0000_0010);
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iOp    = 2'b00;
        bus.iSrc0  = 32'h0001_0003;
        bus.iSrc1  = 32'h0002_0005;
        @(posedge clk);
        #1;
        wait_valid(lat, 1'b0);
        check_result("b2b_first", exp1, lat);
        bus.iOp   = 2'b11;
        bus.iSrc0 = 32'h8000_0001;
        bus.iSrc1 = 32'h0000_0010;
        @(posedge clk);
        #1;
        check_eq("b2b_accept", 64'(bus.oBusy), 64'd1);
        wait_valid(lat, 1'b0);
        check_result("b2b_second", exp2, lat);
        bus.iStart = 1'b0;
        @(posedge clk);
        #1;
        check_eq("b2b_idle", {62'd0, bus.oBusy, bus.oValid}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            run_op("random", 2'($urandom), rnd_operand(), rnd_operand(), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
